orange_template_matcher: RTL
============================

Name: orange_template_matcher

Overview:
- Consumes the orange template ROM: 2048 bytes, 11-bit address, 8-bit data, unregistered output, 1-cycle read latency.
- Streams a 2048-byte feature vector from the ISP pipeline and computes the sum of absolute differences (SAD) against the template.
- Reports the SAD score and a match flag to the fruit-classification decision logic.
- Sits directly downstream of orange_rom: it drives the ROM address and uses the ROM read data.

Parameters:
- ADDR_WIDTH, 11, ROM address width.
- DATA_WIDTH, 8, ROM and feature byte width.
- LEN, 2048, number of bytes compared; must be at most 2**ADDR_WIDTH.
- THRESH, 65536, match asserted when SAD is at most THRESH.
- SAD_WIDTH, ADDR_WIDTH+DATA_WIDTH (19), accumulator width.

Ports:
- clk  in  1  system clock; also clocks the ROM.
- tb_rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a comparison.
- busy  out  1  high from PRIME through DONE.
- feat_valid  in  1  feature byte valid.
- feat_data  in  DATA_WIDTH  feature byte.
- feat_ready  out  1  matcher accepts a feature byte.
- rom_addr  out  ADDR_WIDTH  ROM address (combinational, see Behaviour).
- rom_data  in  DATA_WIDTH  ROM read data, valid one cycle after the address is sampled.
- done  out  1  one-cycle pulse when the result is updated.
- sad  out  SAD_WIDTH  last SAD result, held until the next done.
- match  out  1  (sad <= THRESH), registered together with sad.

Behaviour:
- Reset: tb_rst, asynchronous, active-high; clock clk. All registers clear: state=IDLE, idx=0, acc=0, sad=0, match=0, done=0, busy=0, feat_ready=0.
- FSM states:
  - IDLE: rom_addr=0. start=1 moves to PRIME and clears idx and acc.
  - PRIME: lasts 1 cycle; ROM samples address 0 at its end. Moves to RUN.
  - RUN: feat_ready=1. A handshake (fire = feat_valid & feat_ready) adds |feat_data - rom_data| to acc and increments idx.
    - On fire with idx==LEN-1: go to DONE.
    - Otherwise stay in RUN.
  - DONE: registers sad <= acc_final and match <= (acc_final <= THRESH); done=1 for exactly this cycle. Moves to IDLE.
- rom_addr = fire ? idx+1 : idx, computed combinationally. The ROM therefore presents data for idx during every RUN cycle, giving throughput of 1 byte per cycle with no bubbles.
- At the final byte, idx+1 wraps to 0 (modulo 2**ADDR_WIDTH). This is harmless because the ROM data is unused after that point.
- Absolute difference is computed as an unsigned (DATA_WIDTH+1)-bit subtract, then conditional negate, then zero-extend to SAD_WIDTH. The accumulator cannot overflow: 2048*255 = 522240 < 2**19.
- The sum including the final byte is what is registered to sad.
- Latency with feat_valid held high: done is asserted LEN+2 cycles after the clock edge that samples start (1 PRIME + LEN RUN + DONE).
- Backpressure: feat_valid low in RUN stalls the block. idx, acc and rom_addr hold, and rom_data stays valid for idx.
- start while busy is ignored; there is no restart or queueing.
- feat_data is ignored outside RUN; feat_ready is 0 outside RUN.
- tb_rst mid-run aborts immediately. The partial acc is discarded, sad/match return to 0, and no done pulse is produced.
- The previous sad/match values stay stable through a new run until that run's done pulse.

Test Plan:
- ROM all 0xFF, feature stream all 0xFF, valid held high, start pulsed once:
  - done fires exactly 2050 cycles after start;
  - sad=0, match=1;
  - rom_addr sequence is 0,1,…,2047 with no repeats.
- ROM all 0xFF, feature stream all 0x00 -> sad=522240 (0x7F800), match=0.
- ROM all 0xFF, feature byte i = 0xFF except 0xFE at indices 0, 1023 and 2047 -> sad=3. Checks the first and last bytes and latency alignment.
- Same as the first scenario, but feat_valid driven by pseudo-random 50% gaps:
  - sad=0;
  - exactly 2048 fires;
  - idx and acc hold on every stall cycle.
- Assert tb_rst after 1000 fires -> all outputs 0 within the same cycle and no done pulse. A subsequent start with all-0x00 data -> sad=522240.
- Pulse start at cycles 5 and 500 of a run -> both ignored; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/orange_template_matcher.sv
// orange_template_matcher
//   Streams a LEN-byte feature vector and accumulates the sum of absolute
//   differences (SAD) against the orange template ROM. The ROM is external:
//   it has an unregistered output and registers its address, so read data
//   arrives one cycle after the address is sampled.
//
// Ports
//   clk, tb_rst       clock (also clocks the ROM); async active-high reset
//   start             one-cycle request to begin a comparison
//   busy              high from PRIME through DONE
//   feat_valid/ready  feature byte handshake; feat_ready only in RUN
//   feat_data         feature byte
//   rom_addr          ROM address (combinational look-ahead)
//   rom_data          ROM read data for the address sampled last edge
//   done              one-cycle pulse while the new result is presented
//   sad, match        last result, held until the next done

// Per-lane absolute difference: 9-bit subtract, conditional negate,
// zero-extend to the accumulator width.
module orange_absdiff #(
  parameter int DATA_WIDTH = 8,
  parameter int SAD_WIDTH  = 19
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [SAD_WIDTH-1:0]  y
);
  logic [DATA_WIDTH:0] d;
  logic [DATA_WIDTH:0] mag;

  always_comb begin
    d   = {1'b0, a} - {1'b0, b};
    mag = d[DATA_WIDTH] ? -d : d;
    y   = SAD_WIDTH'(mag);
  end
endmodule

module orange_template_matcher #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int LEN        = 2048,   // at most 2**ADDR_WIDTH
  parameter int THRESH     = 65536,
  parameter int SAD_WIDTH  = ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  start,
  output logic                  busy,
  input  logic                  feat_valid,
  input  logic [DATA_WIDTH-1:0] feat_data,
  output logic                  feat_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  done,
  output logic [SAD_WIDTH-1:0]  sad,
  output logic                  match
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LEN - 1);
  localparam logic [31:0]           THRESH_U = 32'(THRESH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [SAD_WIDTH-1:0]  acc;
  logic [SAD_WIDTH-1:0]  diff;
  logic [SAD_WIDTH-1:0]  acc_next;
  logic                  fire;
  logic                  last;

  assign fire     = feat_valid & feat_ready;
  assign last     = (idx == LAST_IDX);
  assign acc_next = acc + diff;

  orange_absdiff #(
    .DATA_WIDTH (DATA_WIDTH),
    .SAD_WIDTH  (SAD_WIDTH)
  ) u_absdiff (
    .a (feat_data),
    .b (rom_data),
    .y (diff)
  );

  // Look-ahead address: on a fire the ROM must already fetch idx+1 so the
  // next RUN cycle sees its byte with no bubble. On the final byte idx+1
  // wraps to 0; that fetch is never consumed.
  always_comb begin
    rom_addr = idx;
    if (state == IDLE)
      rom_addr = '0;
    else if (fire)
      rom_addr = idx + 1'b1;
  end

  // busy/feat_ready/done are registered mirrors of the next state, so they
  // line up exactly with PRIME..DONE, RUN and DONE respectively. sad/match
  // load on the edge into DONE so they are valid while done is high.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      sad        <= '0;
      match      <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      feat_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= PRIME;
            idx   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
          end
        end
        PRIME: begin
          // ROM samples address 0 at the end of this cycle
          state      <= RUN;
          feat_ready <= 1'b1;
        end
        RUN: begin
          if (fire) begin
            acc <= acc_next;
            idx <= idx + 1'b1;
            if (last) begin
              state      <= DONE;
              feat_ready <= 1'b0;
              sad        <= acc_next;
              match      <= (32'(acc_next) <= THRESH_U);
              done       <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
